// File: rtl/day_9_pkg.sv
// Shared types and helpers for the day_9 binary decoder: mode encoding,
// the index decode function and elaboration-time parameter legality check.
package day_9_pkg;

  typedef enum logic {
    MODE_ONEHOT = 1'b0,
    MODE_THERMO = 1'b1
  } dec_mode_e;

  // Widest vector the decode function can produce; callers slice [OUT_W-1:0].
  localparam int unsigned MAX_OUT_W = 256;
  localparam int unsigned MAX_BIN_W = 16;

  typedef struct packed {
    logic                 err;
    logic [MAX_OUT_W-1:0] vec;
  } dec_res_t;

  // Out-of-range indices decode to all zeros (one-hot) or all ones (thermometer).
  function automatic dec_res_t dec_f(input logic [31:0] bin, input dec_mode_e mode,
                                     input int unsigned out_w);
    dec_res_t res;
    res     = '0;
    res.err = (bin >= out_w);
    for (int unsigned j = 0; j < MAX_OUT_W; j++) begin
      if (j < out_w) begin
        if (mode == MODE_THERMO) res.vec[j] = res.err || (j <= bin);
        else                     res.vec[j] = !res.err && (j == bin);
      end
    end
    return res;
  endfunction

  function automatic bit params_ok(input int unsigned bin_w, input int unsigned out_w,
                                   input int unsigned cnt_w);
    return (bin_w >= 1) && (bin_w <= MAX_BIN_W) && (out_w >= 2) &&
           (out_w <= MAX_OUT_W) && (out_w <= (32'd1 << bin_w)) && (cnt_w >= 1);
  endfunction

endpackage

// File: rtl/day_9_skid_buffer.sv
// Two-entry head/skid stream buffer with registered ready_o; full throughput
// when the consumer keeps ready_i high.
module day_9_skid_buffer
  import day_9_pkg::*;
#(
  parameter int unsigned DW = 17
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          valid_i,
  output logic          ready_o,
  input  logic [DW-1:0] data_i,
  output logic          valid_o,
  input  logic          ready_i,
  output logic [DW-1:0] data_o
);

  logic [DW-1:0] head_q, head_d;
  logic [DW-1:0] skid_q, skid_d;
  logic          head_vld_q, head_vld_d;
  logic          skid_vld_q, skid_vld_d;
  logic          ready_q;
  logic          in_xfer, out_xfer;

  assign in_xfer  = valid_i & ready_q;
  assign out_xfer = head_vld_q & ready_i;

  always_comb begin
    head_d     = head_q;
    skid_d     = skid_q;
    head_vld_d = head_vld_q;
    skid_vld_d = skid_vld_q;
    if (out_xfer) begin
      if (skid_vld_q) begin
        head_d     = skid_q;
        skid_vld_d = 1'b0;
      end else begin
        head_vld_d = 1'b0;
      end
    end
    // ready_q implies the skid is empty, so an accepted beat never overwrites it.
    if (in_xfer) begin
      if (!head_vld_q || (out_xfer && !skid_vld_q)) begin
        head_d     = data_i;
        head_vld_d = 1'b1;
      end else begin
        skid_d     = data_i;
        skid_vld_d = 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      head_q     <= '0;
      skid_q     <= '0;
      head_vld_q <= 1'b0;
      skid_vld_q <= 1'b0;
      ready_q    <= 1'b1;
    end else begin
      head_q     <= head_d;
      skid_q     <= skid_d;
      head_vld_q <= head_vld_d;
      skid_vld_q <= skid_vld_d;
      ready_q    <= !skid_vld_d;
    end
  end

  assign ready_o = ready_q;
  assign valid_o = head_vld_q;
  assign data_o  = head_q;

endmodule

// File: rtl/day_9_binary_decoder_pipe.sv
// Registered binary-to-one-hot/thermometer decoder behind a skid buffer.
// Optional saturating error counter enabled by `define DAY9_DEC_ERR_CNT_EN.
module day_9_binary_decoder_pipe
  import day_9_pkg::*;
#(
  parameter int unsigned BIN_W = 4,
  parameter int unsigned OUT_W = 16,
  parameter int unsigned CNT_W = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             valid_i,
  output logic             ready_o,
  input  logic [BIN_W-1:0] bin_i,
  input  logic             mode_i,
  output logic             valid_o,
  input  logic             ready_i,
  output logic [OUT_W-1:0] vec_o,
`ifdef DAY9_DEC_ERR_CNT_EN
  output logic             err_o,
  output logic [CNT_W-1:0] err_cnt_o
`else
  output logic             err_o
`endif
);

  localparam bit PARAMS_OK = params_ok(BIN_W, OUT_W, CNT_W);

  if (!PARAMS_OK) begin : g_bad_params
    $error("day_9_binary_decoder_pipe: illegal BIN_W/OUT_W/CNT_W combination");
  end

  dec_res_t         dec_res;
  logic [OUT_W:0]   dec_word;
  logic [OUT_W:0]   out_word;
  logic             unused_dec_hi;

  assign dec_res       = dec_f(32'(bin_i), dec_mode_e'(mode_i), OUT_W);
  assign dec_word      = {dec_res.err, dec_res.vec[OUT_W-1:0]};
  assign unused_dec_hi = ^dec_res.vec;

  day_9_skid_buffer #(
    .DW (OUT_W + 1)
  ) u_skid (
    .clk     (clk),
    .reset   (reset),
    .valid_i (valid_i),
    .ready_o (ready_o),
    .data_i  (dec_word),
    .valid_o (valid_o),
    .ready_i (ready_i),
    .data_o  (out_word)
  );

  assign err_o = out_word[OUT_W];
  assign vec_o = out_word[OUT_W-1:0];

`ifdef DAY9_DEC_ERR_CNT_EN
  logic [CNT_W-1:0] err_cnt_q, err_cnt_d;

  // Counted on output transfer, so errored beats stalled in the buffer are not yet counted.
  always_comb begin
    err_cnt_d = err_cnt_q;
    if (valid_o && ready_i && err_o && (err_cnt_q != {CNT_W{1'b1}})) begin
      err_cnt_d = err_cnt_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (reset) err_cnt_q <= '0;
    else       err_cnt_q <= err_cnt_d;
  end

  assign err_cnt_o = err_cnt_q;
`endif

endmodule

// File: tb/tb_day_9_binary_decoder_pipe.sv
// Directed bench: two decoder instances (OUT_W=16 and OUT_W=10) share one input stream.
module tb_day_9_binary_decoder_pipe;

  logic       clk = 1'b0;
  logic       reset;
  logic       valid_i;
  logic [3:0] bin_i;
  logic       mode_i;
  logic       ready_i;

  logic        r16, v16, e16;
  logic [15:0] vec16;
  logic        r10, v10, e10;
  logic [9:0]  vec10;
`ifdef DAY9_DEC_ERR_CNT_EN
  logic [7:0]  cnt16;
  logic [1:0]  cnt10;
`endif

  int n_vec = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  day_9_binary_decoder_pipe #(.BIN_W(4), .OUT_W(16), .CNT_W(8)) u_dut16 (
    .clk (clk), .reset (reset), .valid_i (valid_i), .ready_o (r16),
    .bin_i (bin_i), .mode_i (mode_i), .valid_o (v16), .ready_i (ready_i),
    .vec_o (vec16),
`ifdef DAY9_DEC_ERR_CNT_EN
    .err_o (e16), .err_cnt_o (cnt16)
`else
    .err_o (e16)
`endif
  );

  day_9_binary_decoder_pipe #(.BIN_W(4), .OUT_W(10), .CNT_W(2)) u_dut10 (
    .clk (clk), .reset (reset), .valid_i (valid_i), .ready_o (r10),
    .bin_i (bin_i), .mode_i (mode_i), .valid_o (v10), .ready_i (ready_i),
    .vec_o (vec10),
`ifdef DAY9_DEC_ERR_CNT_EN
    .err_o (e10), .err_cnt_o (cnt10)
`else
    .err_o (e10)
`endif
  );

  typedef struct {
    logic [3:0]  bin;
    logic        mode;
    logic [15:0] vec16;
    logic [9:0]  vec10;
    logic        err10;
  } vec_t;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  vec_t tbl[12];

  initial begin
    tbl[0]  = '{4'd0,  1'b0, 16'h0001, 10'h001, 1'b0};
    tbl[1]  = '{4'd7,  1'b0, 16'h0080, 10'h080, 1'b0};
    tbl[2]  = '{4'd9,  1'b0, 16'h0200, 10'h200, 1'b0};
    tbl[3]  = '{4'd12, 1'b0, 16'h1000, 10'h000, 1'b1};
    tbl[4]  = '{4'd15, 1'b0, 16'h8000, 10'h000, 1'b1};
    tbl[5]  = '{4'd0,  1'b1, 16'h0001, 10'h001, 1'b0};
    tbl[6]  = '{4'd7,  1'b1, 16'h00FF, 10'h0FF, 1'b0};
    tbl[7]  = '{4'd9,  1'b1, 16'h03FF, 10'h3FF, 1'b0};
    tbl[8]  = '{4'd12, 1'b1, 16'h1FFF, 10'h3FF, 1'b1};
    tbl[9]  = '{4'd15, 1'b1, 16'hFFFF, 10'h3FF, 1'b1};
    tbl[10] = '{4'd10, 1'b0, 16'h0400, 10'h000, 1'b1};
    tbl[11] = '{4'd10, 1'b1, 16'h07FF, 10'h3FF, 1'b1};

    reset = 1'b1; valid_i = 1'b0; bin_i = '0; mode_i = 1'b0; ready_i = 1'b1;
    tick(); tick();
    chk("rst_valid", 32'(v16), 32'd0);
    chk("rst_vec",   32'(vec16), 32'd0);
    chk("rst_err",   32'(e16), 32'd0);
    chk("rst_ready", 32'(r16), 32'd1);
    chk("rst_vec10", 32'(vec10), 32'd0);
`ifdef DAY9_DEC_ERR_CNT_EN
    chk("rst_cnt",   32'(cnt10), 32'd0);
`endif
    reset = 1'b0;
    tick();

    // One-hot sweep, one beat per cycle.
    mode_i = 1'b0;
    for (int i = 0; i < 16; i++) begin
      valid_i = 1'b1; bin_i = 4'(i);
      tick();
      chk("sweep_valid", 32'(v16), 32'd1);
      chk("sweep_vec",   32'(vec16), 32'd1 << i);
      chk("sweep_err",   32'(e16), 32'd0);
      chk("sweep_ready", 32'(r16), 32'd1);
    end
    valid_i = 1'b0;
    tick();
    chk("sweep_drain", 32'(v16), 32'd0);

    for (int i = 0; i < 12; i++) begin
      valid_i = 1'b1; bin_i = tbl[i].bin; mode_i = tbl[i].mode;
      tick();
      chk("tbl_vec16", 32'(vec16), 32'(tbl[i].vec16));
      chk("tbl_err16", 32'(e16), 32'd0);
      chk("tbl_vec10", 32'(vec10), 32'(tbl[i].vec10));
      chk("tbl_err10", 32'(e10), 32'(tbl[i].err10));
      chk("tbl_v10",   32'(v10), 32'd1);
    end
    valid_i = 1'b0;
    tick();

    // Backpressure: 3 offered, 2 accepted, third blocked.
    ready_i = 1'b0; mode_i = 1'b0;
    valid_i = 1'b1; bin_i = 4'd3;
    tick();
    chk("bp_v1",     32'(v16), 32'd1);
    chk("bp_vec1",   32'(vec16), 32'h0008);
    chk("bp_rdy1",   32'(r16), 32'd1);
    bin_i = 4'd5;
    tick();
    chk("bp_rdy2",   32'(r16), 32'd0);
    chk("bp_vec2",   32'(vec16), 32'h0008);
    bin_i = 4'd9;
    tick();
    chk("bp_rdy3",   32'(r16), 32'd0);
    chk("bp_vec3",   32'(vec16), 32'h0008);
    tick();
    chk("bp_hold_v", 32'(v16), 32'd1);
    chk("bp_hold",   32'(vec16), 32'h0008);
    valid_i = 1'b0;
    ready_i = 1'b1;
    tick();
    chk("bp_out2_v", 32'(v16), 32'd1);
    chk("bp_out2",   32'(vec16), 32'h0020);
    chk("bp_rdy_up", 32'(r16), 32'd1);
    tick();
    chk("bp_empty",  32'(v16), 32'd0);
    tick();
    chk("bp_nodup",  32'(v16), 32'd0);

    // Reset with two entries held.
    ready_i = 1'b0;
    valid_i = 1'b1; bin_i = 4'd1; tick();
    bin_i = 4'd2; tick();
    chk("mr_full",   32'(r16), 32'd0);
    reset = 1'b1; bin_i = 4'd4;
    tick();
    chk("mr_valid",  32'(v16), 32'd0);
    chk("mr_ready",  32'(r16), 32'd1);
    chk("mr_vec",    32'(vec16), 32'd0);
    reset = 1'b0; valid_i = 1'b0; ready_i = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("mr_stale", 32'(v16), 32'd0);
    end

`ifdef DAY9_DEC_ERR_CNT_EN
    begin
      logic [1:0] exp_cnt[5];
      exp_cnt[0] = 2'd1; exp_cnt[1] = 2'd2; exp_cnt[2] = 2'd3;
      exp_cnt[3] = 2'd3; exp_cnt[4] = 2'd3;
      reset = 1'b1; tick(); reset = 1'b0;
      ready_i = 1'b0; mode_i = 1'b0;
      valid_i = 1'b1; bin_i = 4'd12;
      tick();
      valid_i = 1'b0;
      for (int i = 0; i < 3; i++) begin
        tick();
        chk("cnt_held", 32'(cnt10), 32'd0);
      end
      ready_i = 1'b1;
      for (int k = 0; k < 5; k++) begin
        valid_i = (k < 4);
        tick();
        chk("cnt_sat", 32'(cnt10), 32'(exp_cnt[k]));
      end
      valid_i = 1'b0;
    end
`endif

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/day_9_binary_decoder_pipe.md
# day_9_binary_decoder_pipe

- Parametrised, registered binary decoder with a valid/ready stream interface on both sides.
- Converts a BIN_W-bit index into an OUT_W-bit vector, either one-hot or thermometer coded, and flags indices that do not fit in OUT_W.
- A 2-entry skid buffer gives full throughput with a registered ready_o.
- Sits between index producers (arbiters, address/select generators) and consumers that need a select vector.

## Interface
- BIN_W, 4: index width; ≥1.
- OUT_W, 16: output vector width; 2 ≤ OUT_W ≤ 2**BIN_W.
- CNT_W, 8: error counter width (used only with DAY9_DEC_ERR_CNT_EN).

Ports. Single clock; reset is synchronous and active-high.
- clk  input  1  clock, rising edge.
- reset  input  1  synchronous, active-high reset.
- valid_i  input  1  input index valid.
- ready_o  output  1  block can accept; registered.
- bin_i  input  BIN_W  binary index.
- mode_i  input  1  0 = one-hot, 1 = thermometer; sampled with bin_i.
- valid_o  output  1  output vector valid.
- ready_i  input  1  downstream accepts.
- vec_o  output  OUT_W  decoded vector.
- err_o  output  1  index was ≥ OUT_W.
- err_cnt_o  output  CNT_W  saturating error count; present only with DAY9_DEC_ERR_CNT_EN.

## Operation
- Input transfer: valid_i & ready_o on a rising edge. Output transfer: valid_o & ready_i.
- One-hot mode, bin_i < OUT_W: vec bit j = (j == bin_i).
- Thermometer mode, bin_i < OUT_W: vec bit j = (j ≤ bin_i). Example: bin 0 gives 0x0001; bin 15 gives 0xFFFF.
- Out of range, bin_i ≥ OUT_W (possible only when OUT_W < 2**BIN_W):
  - err = 1.
  - One-hot mode: vec = 0.
  - Thermometer mode: vec = all ones.
- The decode is computed combinationally at input and registered together with err.
- Storage is an output register (head) plus one skid register. Maximum occupancy is 2.
- On an accepted input:
  - If head is empty, or head is being transferred this cycle and skid is empty, the data goes to head.
  - Otherwise it goes to skid.
- On an output transfer with skid full: skid moves to head, and skid is freed.
- ready_o next = skid empty next cycle.
- Simultaneous input and output transfer with skid empty: head is replaced, occupancy is unchanged, no bubble.
- valid_o and vec_o are held stable while valid_o & ~ready_i. Required: no change until transfer.
- Inputs are ignored while reset is high.

## Timing
- Latency: input transfer at edge N gives valid_o high after edge N (visible in cycle N+1).
- Throughput: 1 transfer per cycle when ready_i is held high.
- ready_o falls the cycle after the skid fills. It rises the cycle after the skid drains.
- Reset values:
  - valid_o = 0, vec_o = 0, err_o = 0.
  - ready_o = 1.
  - skid empty; err_cnt_o = 0.
- Reset mid-operation discards both entries in the same cycle.

## Configuration
- DAY9_DEC_ERR_CNT_EN defined:
  - err_cnt_o is present.
  - It increments on each output transfer with err_o = 1.
  - It saturates at 2**CNT_W−1 and clears only on reset.
- Not defined: err_cnt_o and the counter logic are absent. All other behaviour is identical.

## Structure
- Package day_9_pkg contains:
  - dec_mode_e enum (MODE_ONEHOT = 0, MODE_THERMO = 1).
  - A decode function f(bin, mode) returning {err, vec}.
  - Parameter legality checks as localparam asserts.
- Sub-module day_9_skid_buffer, parametrised on data width (OUT_W+1), implements the head/skid storage and handshake. The top-level instantiates it after the decode logic.

## Test plan
- Sweep, one-hot mode: BIN_W=4, OUT_W=16, ready_i=1, bin 0..15 one per cycle → vec_o = 1<<bin one cycle later, err_o = 0, 16 beats in 16 cycles.
- Thermometer mode: bin 0, 7, 15 → vec_o = 0x0001, 0x00FF, 0xFFFF.
- Out of range: BIN_W=4, OUT_W=10:
  - bin 12 in one-hot mode → vec_o = 0x000, err_o = 1.
  - Same in thermometer mode → 0x3FF, err_o = 1.
- Backpressure:
  - Hold ready_i=0, stream 3 indices → 2 accepted, ready_o = 0 from the cycle after the second.
  - vec_o stays stable.
  - Release ready_i → outputs in order, ready_o rises one cycle after the skid drains, no loss or duplication.
- Reset mid-operation: with 2 entries held, assert reset for 1 cycle → valid_o = 0, ready_o = 1, vec_o = 0 next cycle, and no stale data appears afterwards.
- With DAY9_DEC_ERR_CNT_EN and CNT_W=2: 5 errored transfers → err_cnt_o = 1, 2, 3, 3, 3. Errored entries held under backpressure are not counted until transferred.
